// File: rtl/mem_arbiter_pkg.sv
// Shared widths, size/state codes and small helpers for the byte-serial memory arbiter.
package mem_arbiter_pkg;

    localparam int InstAddrBus = 32;
    localparam int DataBus     = 8;
    localparam int RegBus      = 32;

    localparam logic [1:0] MemByte = 2'b00;
    localparam logic [1:0] MemHalf = 2'b01;
    localparam logic [1:0] MemWord = 2'b10;

    // Address bits [17:16] both set select the IO window.
    localparam logic [31:0] IoAddrMask = 32'h0003_0000;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbRd   = 2'd1,
        ArbWr   = 2'd2,
        ArbDone = 2'd3
    } arb_state_e;

    typedef enum logic {
        PortLs = 1'b0,
        PortIf = 1'b1
    } arb_port_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            MemByte: return 3'd1;
            MemHalf: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [31:0] addr);
        return (addr & IoAddrMask) == IoAddrMask;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the 8-bit RAM/IO port between instruction fetch and load/store,
// sequencing bytes little-endian and returning a one-cycle done pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req_i,
    input  logic [InstAddrBus-1:0] if_addr_i,
    input  logic                   if_flush_i,
    output logic                   if_done_o,
    output logic [RegBus-1:0]      if_inst_o,
    input  logic                   ls_req_i,
    input  logic                   ls_we_i,
    input  logic [1:0]             ls_size_i,
    input  logic [InstAddrBus-1:0] ls_addr_i,
    input  logic [RegBus-1:0]      ls_wdata_i,
    output logic                   ls_done_o,
    output logic [RegBus-1:0]      ls_rdata_o,
    input  logic [DataBus-1:0]     mem_din_i,
    output logic [DataBus-1:0]     mem_dout_o,
    output logic [InstAddrBus-1:0] mem_a_o,
    output logic                   mem_wr_o,
    input  logic                   io_buffer_full_i,
    output logic                   busy_o
);

    arb_state_e       state_q, state_d;
    arb_port_e        port_q, port_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0][7:0]  lane_q, lane_d;

    logic [InstAddrBus-1:0] mem_a_d;
    logic                   mem_wr_d;
    logic [DataBus-1:0]     mem_dout_d;
    logic                   if_done_d, ls_done_d, busy_d;
    logic [RegBus-1:0]      if_inst_d, ls_rdata_d;

    logic       ls_ok, if_ok;
    logic [2:0] n_q;

    // In DONE the port that just finished must not be re-granted on its stale req.
    assign ls_ok = ls_req_i && !(state_q == ArbDone && port_q == PortLs);
    assign if_ok = if_req_i && !if_flush_i && !(state_q == ArbDone && port_q == PortIf);
    assign n_q   = (port_q == PortIf) ? 3'd4 : size_bytes(ls_size_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ArbIdle;
            port_q  <= PortLs;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
        end
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        case (state_q)
            ArbIdle, ArbDone: begin
                if (ls_ok) begin
                    state_d = ls_we_i ? ArbWr : ArbRd;
                    port_d  = PortLs;
                end else if (if_ok) begin
                    state_d = ArbRd;
                    port_d  = PortIf;
                end else begin
                    state_d = ArbIdle;
                end
            end
            ArbRd: begin
                if (port_q == PortIf && if_flush_i) state_d = ArbIdle;
                else if (cnt_q == n_q)              state_d = ArbDone;
            end
            ArbWr: begin
                if (mem_wr_o && (cnt_q + 3'd1 == n_q)) state_d = ArbDone;
            end
            default: state_d = ArbIdle;
        endcase
    end

    logic [2:0]             nxt_idx, n_d;
    logic [InstAddrBus-1:0] sel_addr, nxt_addr;
    logic                   io_stall;
    logic [1:0]             cap_idx;

    always_comb begin
        mem_a_d    = '0;
        mem_wr_d   = 1'b0;
        mem_dout_d = '0;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_inst_d  = if_inst_o;
        ls_rdata_d = ls_rdata_o;
        busy_d     = (state_d != ArbIdle);

        sel_addr = (port_d == PortIf) ? if_addr_i : ls_addr_i;
        n_d      = (port_d == PortIf) ? 3'd4 : size_bytes(ls_size_i);
        // A stalled write keeps its byte index and retries it next edge.
        case (state_q)
            ArbRd:   nxt_idx = cnt_q + 3'd1;
            ArbWr:   nxt_idx = mem_wr_o ? cnt_q + 3'd1 : cnt_q;
            default: nxt_idx = 3'd0;
        endcase
        nxt_addr = sel_addr + {29'd0, nxt_idx};
        io_stall = is_io(nxt_addr) && io_buffer_full_i;
        cap_idx  = cnt_q[1:0] - 2'd1;

        // Data for the byte presented last cycle arrives now.
        if (state_q == ArbRd && cnt_q != 3'd0) lane_d[cap_idx] = mem_din_i;

        case (state_d)
            ArbRd: begin
                if (state_q != ArbRd) lane_d = '0;
                cnt_d = nxt_idx;
                if (nxt_idx < n_d) mem_a_d = nxt_addr;
            end
            ArbWr: begin
                if (state_q != ArbWr) lane_d = '0;
                cnt_d = nxt_idx;
                if (!io_stall) begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = nxt_addr;
                    mem_dout_d = ls_wdata_i[{nxt_idx[1:0], 3'b000} +: 8];
                end
            end
            ArbDone: begin
                if (port_q == PortIf) begin
                    if_done_d = 1'b1;
                    if_inst_d = lane_d;
                end else begin
                    ls_done_d = 1'b1;
                    if (state_q == ArbRd) ls_rdata_d = lane_d;
                end
            end
            default: begin
                if (state_q == ArbRd) lane_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            lane_q     <= '0;
            mem_a_o    <= '0;
            mem_wr_o   <= 1'b0;
            mem_dout_o <= '0;
            if_done_o  <= 1'b0;
            if_inst_o  <= '0;
            ls_done_o  <= 1'b0;
            ls_rdata_o <= '0;
            busy_o     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            mem_a_o    <= mem_a_d;
            mem_wr_o   <= mem_wr_d;
            mem_dout_o <= mem_dout_d;
            if_done_o  <= if_done_d;
            if_inst_o  <= if_inst_d;
            ls_done_o  <= ls_done_d;
            ls_rdata_o <= ls_rdata_d;
            busy_o     <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of LS transfers plus hand-written grant/flush/stall/reset sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, if_flush_i, if_done_o;
    logic [31:0] if_addr_i, if_inst_o;
    logic        ls_req_i, ls_we_i, ls_done_o;
    logic [1:0]  ls_size_i;
    logic [31:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
    logic [7:0]  mem_din_i, mem_dout_o;
    logic [31:0] mem_a_o;
    logic        mem_wr_o, io_buffer_full_i, busy_o;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_done_o(if_done_o), .if_inst_o(if_inst_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i),
        .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
        .ls_done_o(ls_done_o), .ls_rdata_o(ls_rdata_o),
        .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o),
        .mem_wr_o(mem_wr_o), .io_buffer_full_i(io_buffer_full_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // RAM: address in cycle c returns data in cycle c+1.
    logic [7:0] ram [logic [31:0]];
    always @(posedge clk) mem_din_i <= ram.exists(mem_a_o) ? ram[mem_a_o] : 8'h00;

    typedef struct { logic is_if; logic chk_val; logic [31:0] val; } sb_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] data; logic io; int lat; } vec_t;

    sb_t  sb_q[$];
    wr_t  wr_q[$];
    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic monitor();
        sb_t e;
        wr_t w;
        if (ls_done_o) begin
            if (sb_q.size() == 0 || sb_q[0].is_if) chk("ls_done_unexpected", 32'd1, 32'd0);
            else begin
                e = sb_q.pop_front();
                if (e.chk_val) chk("ls_rdata", ls_rdata_o, e.val);
            end
        end
        if (if_done_o) begin
            if (sb_q.size() == 0 || !sb_q[0].is_if) chk("if_done_unexpected", 32'd1, 32'd0);
            else begin
                e = sb_q.pop_front();
                chk("if_inst", if_inst_o, e.val);
            end
        end
        if (mem_wr_o) begin
            if (wr_q.size() == 0) chk("write_unexpected", mem_a_o, 32'hFFFF_FFFF);
            else begin
                w = wr_q.pop_front();
                chk("wr_addr", mem_a_o, w.addr);
                chk("wr_data", {24'd0, mem_dout_o}, {24'd0, w.data});
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        for (int k = 0; k < 4; k++) ram[addr + 32'(k)] = data[8*k +: 8];
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_a"}, mem_a_o, 32'd0);
        chk({tag, "_mem_wr"}, {31'd0, mem_wr_o}, 32'd0);
        chk({tag, "_dout"}, {24'd0, mem_dout_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_ls_done"}, {31'd0, ls_done_o}, 32'd0);
        chk({tag, "_if_done"}, {31'd0, if_done_o}, 32'd0);
        chk({tag, "_ls_rdata"}, ls_rdata_o, 32'd0);
        chk({tag, "_if_inst"}, if_inst_o, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int          n, c;
        logic [31:0] mask, exp_a;
        logic        got;
        n    = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
        mask = (n == 1) ? 32'hFF : (n == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!v.we) begin
            preload(v.addr, v.data);
            sb_q.push_back('{1'b0, 1'b1, v.data & mask});
        end else begin
            for (int k = 0; k < n; k++) wr_q.push_back('{v.addr + 32'(k), v.data[8*k +: 8]});
            sb_q.push_back('{1'b0, 1'b0, 32'd0});
        end
        ls_req_i = 1'b1; ls_we_i = v.we; ls_size_i = v.size;
        ls_addr_i = v.addr; ls_wdata_i = v.data; io_buffer_full_i = v.io;
        got = 1'b0;
        c = 0;
        while (!got && c < 30) begin
            step();
            c++;
            exp_a = (c <= n) ? v.addr + 32'(c - 1) : 32'd0;
            chk("mem_a_seq", mem_a_o, exp_a);
            if (ls_done_o) got = 1'b1;
        end
        if (!got) chk("ls_done_timeout", 32'd0, 32'd1);
        chk("latency", 32'(c), 32'(v.lat));
        ls_req_i = 1'b0;
        io_buffer_full_i = 1'b0;
        step();
        chk("done_width", {31'd0, ls_done_o}, 32'd0);
        chk("idle_after", {31'd0, busy_o}, 32'd0);
        if (!v.we) chk("rdata_hold", ls_rdata_o, v.data & mask);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ls_at, if_at, done_at;

        vecs[0] = '{1'b0, 2'b10, 32'h0000_0100, 32'h4433_2211, 1'b0, 6};
        vecs[1] = '{1'b0, 2'b00, 32'h0000_0010, 32'hDDCC_BB80, 1'b0, 3};
        vecs[2] = '{1'b0, 2'b01, 32'h0000_2002, 32'h1234_ABCD, 1'b0, 4};
        vecs[3] = '{1'b0, 2'b11, 32'h0000_3000, 32'hCAFE_F00D, 1'b0, 6};
        vecs[4] = '{1'b1, 2'b01, 32'h0000_0200, 32'h0000_BEEF, 1'b0, 3};
        vecs[5] = '{1'b1, 2'b00, 32'h0000_0040, 32'h7766_5541, 1'b0, 2};
        vecs[6] = '{1'b1, 2'b10, 32'h0000_0500, 32'hDEAD_BEEF, 1'b0, 5};
        vecs[7] = '{1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0403_0201, 1'b0, 6};
        vecs[8] = '{1'b1, 2'b10, 32'hFFFF_FFFF, 32'h1122_3344, 1'b0, 5};
        vecs[9] = '{1'b0, 2'b00, 32'h0003_0001, 32'h9988_775A, 1'b1, 3};

        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
        ls_req_i = 1'b0; ls_we_i = 1'b0; ls_size_i = '0; ls_addr_i = '0; ls_wdata_i = '0;
        io_buffer_full_i = 1'b0;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // LS and IF together: LS wins, IF granted in LS's DONE cycle.
        preload(32'h10, 32'hEEDD_FF80);
        preload(32'h0, 32'h0050_0513);
        sb_q.push_back('{1'b0, 1'b1, 32'h0000_0080});
        sb_q.push_back('{1'b1, 1'b1, 32'h0050_0513});
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'b00; ls_addr_i = 32'h10;
        if_req_i = 1'b1; if_addr_i = 32'h0;
        ls_at = -1; if_at = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (ls_done_o) begin ls_at = c; ls_req_i = 1'b0; end
            if (if_done_o) begin if_at = c; if_req_i = 1'b0; end
            if (c == 4) chk("if_busy_c4", {31'd0, busy_o}, 32'd1);
            if (c == 5) chk("if_addr_c5", mem_a_o, 32'd1);
            if (c == 7) chk("if_addr_c7", mem_a_o, 32'd3);
        end
        chk("contend_ls_cycle", 32'(ls_at), 32'd3);
        chk("contend_if_cycle", 32'(if_at), 32'd9);

        // IF fetch aborted by a flush pulse in cycle 3.
        preload(32'h0, 32'h1234_5678);
        if_req_i = 1'b1; if_addr_i = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            step();
            chk("flush_no_done", {31'd0, if_done_o}, 32'd0);
            if (c == 3) begin if_flush_i = 1'b1; if_req_i = 1'b0; end
            if (c == 4) begin
                chk("flush_idle", {31'd0, busy_o}, 32'd0);
                chk("flush_addr", mem_a_o, 32'd0);
                if_flush_i = 1'b0;
            end
        end

        // SB into IO space with the output buffer full for three edges.
        wr_q.push_back('{32'h0003_0000, 8'h41});
        sb_q.push_back('{1'b0, 1'b0, 32'd0});
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_size_i = 2'b00;
        ls_addr_i = 32'h0003_0000; ls_wdata_i = 32'h0000_0041; io_buffer_full_i = 1'b1;
        done_at = -1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c <= 3) chk("io_stall_wr", {31'd0, mem_wr_o}, 32'd0);
            if (c <= 3) chk("io_stall_addr", mem_a_o, 32'd0);
            if (c == 3) io_buffer_full_i = 1'b0;
            if (c == 4) chk("io_write", {31'd0, mem_wr_o}, 32'd1);
            if (ls_done_o) begin done_at = c; ls_req_i = 1'b0; end
        end
        chk("io_done_cycle", 32'(done_at), 32'd5);

        // Reset lands during an SW: only the first two bytes get written.
        wr_q.push_back('{32'h0000_0600, 8'h04});
        wr_q.push_back('{32'h0000_0601, 8'h03});
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_size_i = 2'b10;
        ls_addr_i = 32'h0000_0600; ls_wdata_i = 32'h0102_0304;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk("rst_no_done", {31'd0, ls_done_o}, 32'd0);
            if (c == 2) rst = 1'b1;
            if (c == 3) begin
                check_zero("midrst");
                rst = 1'b0;
                ls_req_i = 1'b0;
            end
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("wr_empty", 32'(wr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
